// File: rtl/burst_request_arbiter_pkg.sv
// Shared types for the burst request arbiter.
package burst_request_arbiter_pkg;

  // Channel ownership state: IDLE arbitrates, BURST holds the lock for one owner.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_arb_state_t;

  localparam int DEFAULT_NUM_REQUESTERS   = 4;
  localparam int DEFAULT_DATA_WIDTH       = 32;
  localparam int DEFAULT_BEAT_COUNT_WIDTH = 4;

endpackage

// File: rtl/burst_request_arbiter_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, priority rotates
// past the winner only when update_lru is pulsed.
module arbiter #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] request,
  input  logic                   update_lru,
  output logic [NUM_ENTRIES-1:0] grant_oh
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  logic [IDX_W-1:0] r_priority;
  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W-1:0] w_next_priority;
  logic             w_found;
  int unsigned      w_pos;

  // Scan requesters starting at the current highest-priority index.
  always_comb begin
    grant_oh    = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_pos       = 0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_pos = int'(r_priority) + i;
      if (w_pos >= NUM_ENTRIES) begin
        w_pos = w_pos - NUM_ENTRIES;
      end
      if (!w_found && request[IDX_W'(w_pos)]) begin
        w_found                  = 1'b1;
        grant_oh[IDX_W'(w_pos)]  = 1'b1;
        w_grant_idx              = IDX_W'(w_pos);
      end
    end
  end

  // The entry after the winner becomes highest priority.
  always_comb begin
    w_next_priority = (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + 1'b1;
  end

  // Priority pointer; rotates only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_priority <= '0;
    end else if (update_lru && w_found) begin
      r_priority <= w_next_priority;
    end
  end

endmodule

// File: rtl/burst_request_arbiter.sv
// Burst request arbiter: locks one downstream beat channel to the
// round-robin winner for a whole multi-beat burst, then re-arbitrates.
module burst_request_arbiter
  import burst_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS   = DEFAULT_NUM_REQUESTERS,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int BEAT_COUNT_WIDTH = DEFAULT_BEAT_COUNT_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [NUM_REQUESTERS-1:0]                        req_valid,
  input  logic [NUM_REQUESTERS-1:0][BEAT_COUNT_WIDTH-1:0]  req_len,
  input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]        req_data,
  output logic [NUM_REQUESTERS-1:0]                        req_ready,
  output logic                                             out_valid,
  output logic [DATA_WIDTH-1:0]                            out_data,
  output logic                                             out_last,
  output logic [$clog2(NUM_REQUESTERS)-1:0]                out_source_id,
  input  logic                                             out_ready
);

  localparam int ID_W = $clog2(NUM_REQUESTERS);

  burst_arb_state_t              r_state;
  burst_arb_state_t              w_state_next;
  logic [NUM_REQUESTERS-1:0]     r_owner_oh;
  logic [NUM_REQUESTERS-1:0]     w_owner_next;
  logic [BEAT_COUNT_WIDTH-1:0]   r_beats_remaining;
  logic [BEAT_COUNT_WIDTH-1:0]   w_beats_next;

  logic [NUM_REQUESTERS-1:0]     w_grant_oh;
  logic                          w_update_lru;
  logic [BEAT_COUNT_WIDTH-1:0]   w_grant_len;
  logic [ID_W-1:0]               w_owner_idx;
  logic [DATA_WIDTH-1:0]         w_owner_data;
  logic                          w_owner_valid;
  logic                          w_xfer;

  arbiter #(
    .NUM_ENTRIES(NUM_REQUESTERS)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   (req_valid),
    .update_lru(w_update_lru),
    .grant_oh  (w_grant_oh)
  );

  // Select the winner's burst length through the one-hot grant.
  always_comb begin
    w_grant_len = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (w_grant_oh[i]) begin
        w_grant_len = w_grant_len | req_len[i];
      end
    end
  end

  // Encode the owner and steer its valid/payload through the one-hot lock.
  always_comb begin
    w_owner_idx   = '0;
    w_owner_data  = '0;
    w_owner_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (r_owner_oh[i]) begin
        w_owner_idx   = w_owner_idx | ID_W'(i);
        w_owner_data  = w_owner_data | req_data[i];
        w_owner_valid = w_owner_valid | req_valid[i];
      end
    end
  end

  // Next-state and output logic; everything is held quiet while reset is high.
  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner_oh;
    w_beats_next  = r_beats_remaining;
    w_update_lru  = 1'b0;
    w_xfer        = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;
    out_source_id = '0;
    req_ready     = '0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            w_update_lru = 1'b1;
            w_owner_next = w_grant_oh;
            w_beats_next = w_grant_len;
            w_state_next = BURST;
          end
        end
        BURST: begin
          out_valid     = w_owner_valid;
          out_data      = w_owner_data;
          out_source_id = w_owner_idx;
          out_last      = (r_beats_remaining == '0);
          req_ready     = r_owner_oh & {NUM_REQUESTERS{out_ready}};
          w_xfer        = w_owner_valid & out_ready;
          if (w_xfer) begin
            if (r_beats_remaining == '0) begin
              w_state_next = IDLE;
              w_owner_next = '0;
            end else begin
              w_beats_next = r_beats_remaining - 1'b1;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
          w_owner_next = '0;
          w_beats_next = '0;
        end
      endcase
    end
  end

  // State, ownership lock and beat counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= IDLE;
      r_owner_oh        <= '0;
      r_beats_remaining <= '0;
    end else begin
      r_state           <= w_state_next;
      r_owner_oh        <= w_owner_next;
      r_beats_remaining <= w_beats_next;
    end
  end

`ifndef SYNTHESIS
  a_owner_onehot_in_burst : assert property (@(posedge clk) disable iff (reset)
    (r_state == BURST) |-> $onehot(r_owner_oh));
  a_owner_zero_in_idle : assert property (@(posedge clk) disable iff (reset)
    (r_state == IDLE) |-> (r_owner_oh == '0));
  a_ready_onehot0 : assert property (@(posedge clk)
    $onehot0(req_ready));
`endif

endmodule
